// File: rtl/dm_cache_wb.sv
// Direct-mapped write-back, write-allocate cache between a single CPU port and a beat-based memory port.
// Hits complete one cycle after acceptance; misses write back a dirty victim line, then refill word by word.
module dm_cache_wb #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int LINES  = 32,
  parameter int WORDS  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              cpu_busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_first;
  logic [OFF_W-1:0]  r_beat;
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [0:LINES-1];
  logic [DATA_W-1:0] r_data [0:LINES*WORDS-1];

  logic [OFF_W-1:0]  w_off;
  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_last;

  assign w_off  = r_addr[OFF_W-1:0];
  assign w_idx  = r_addr[OFF_W +: IDX_W];
  assign w_tag  = r_addr[ADDR_W-1 -: TAG_W];
  assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_last = (r_beat == OFF_W'(WORDS - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are decoded from state so that reset forces them to zero immediately.
  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    cpu_busy  = (r_state != S_IDLE);
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) begin
          w_next = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (w_hit) begin
          cpu_ready = 1'b1;
          cpu_rdata = r_data[{w_idx, w_off}];
          w_next    = S_IDLE;
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_next = S_WRITEBACK;
        end else begin
          w_next = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {r_tag[w_idx], w_idx, r_beat};
        mem_wdata = r_data[{w_idx, r_beat}];
        if (mem_ack && w_last) begin
          w_next = S_REFILL;
        end
      end
      S_REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, r_beat};
        if (mem_ack && w_last) begin
          w_next = S_LOOKUP;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_first  <= 1'b0;
      r_beat   <= '0;
      r_valid  <= '0;
      r_dirty  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_first <= 1'b1;
          end
        end
        S_LOOKUP: begin
          // Only the first lookup of a request is a real hit/miss event; the post-refill one is not counted.
          r_first <= 1'b0;
          r_beat  <= '0;
          if (r_first) begin
            if (w_hit) begin
              if (hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            end else begin
              if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            end
          end
          if (w_hit && r_we) begin
            r_dirty[w_idx] <= 1'b1;
          end
        end
        S_WRITEBACK: begin
          if (mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) begin
              r_dirty[w_idx] <= 1'b0;
            end
          end
        end
        S_REFILL: begin
          if (mem_ack) begin
            r_beat <= r_beat + OFF_W'(1);
            if (w_last) begin
              r_valid[w_idx] <= 1'b1;
              r_dirty[w_idx] <= 1'b0;
            end
          end
        end
        default: begin
          r_beat <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_ack && w_last) begin
      r_tag[w_idx] <= w_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_REFILL && mem_ack) begin
      r_data[{w_idx, r_beat}] <= mem_rdata;
    end else if (r_state == S_LOOKUP && w_hit && r_we) begin
      r_data[{w_idx, w_off}] <= r_wdata;
    end
  end

endmodule
